// File: rtl/sm_accum_ctrl.sv
// Sign-magnitude accumulation sequencer for one neuron: bias load,
// product streaming through the shared adder, saturation, result handoff.
module sm_accum_ctrl #(
  parameter int WORD_LENGTH = 16,
  parameter int NUM_INPUTS  = 4,
  parameter int CNT_W       = $clog2(NUM_INPUTS) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] bias,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic [WORD_LENGTH-1:0] add_a,
  output logic [WORD_LENGTH-1:0] add_b,
  input  logic [WORD_LENGTH-1:0] add_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int W = WORD_LENGTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic           ovf, ovf_nx;
  logic           wrap;
  logic [W-1:0]   upd;

  function automatic logic [W-1:0] norm(input logic [W-1:0] v);
    return (v[W-2:0] == '0) ? '0 : v;
  endfunction

  // Same-sign add whose magnitude shrank has wrapped past full scale.
  assign wrap = (acc[W-1] == in_data[W-1]) &&
                (add_sum[W-2:0] < acc[W-2:0]);
  assign upd  = wrap ? {acc[W-1], {(W-1){1'b1}}}
                     : norm(add_sum);
  assign add_a = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    ovf_nx    = ovf;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_ovf   = 1'b0;
    add_b     = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nx   = norm(bias);
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        add_b    = in_data;
        if (in_valid) begin
          acc_nx = upd;
          ovf_nx = ovf | wrap;
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == LAST) state_nx = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = acc;
        out_ovf   = ovf;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sm_accum_ctrl.sv
// Bench for sm_accum_ctrl: vector table, corner sequences and
// randomized runs against an integer-arithmetic reference model.
module tb_sm_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef logic [3:0][15:0] beats_t;

  typedef struct {
    logic [15:0] bias;
    beats_t      beats;
    logic [15:0] exp_data;
    logic        exp_ovf;
    int          gap;
    int          stall;
    bit          poke;
  } vec_t;

  sm_accum_ctrl #(
    .WORD_LENGTH(16),
    .NUM_INPUTS (4),
    .CNT_W      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // External shared adder, modelled from its contract.
  always_comb begin
    add_sum = '0;
    if (add_a[15] == add_b[15])
      add_sum = {add_a[15], add_a[14:0] + add_b[14:0]};
    else if (add_a[14:0] > add_b[14:0])
      add_sum = {add_a[15], add_a[14:0] - add_b[14:0]};
    else if (add_b[14:0] > add_a[14:0])
      add_sum = {add_b[15], add_b[14:0] - add_a[14:0]};
    else
      add_sum = {add_b[15], 15'd0};
  end

  function automatic int sm2i(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  function automatic logic [15:0] i2sm(input int x);
    if (x < 0) return {1'b1, 15'(-x)};
    return {1'b0, 15'(x)};
  endfunction

  function automatic void ref_run(input logic [15:0] b,
                                  input beats_t bt,
                                  output logic [15:0] d,
                                  output logic o);
    int s;
    o = 1'b0;
    s = sm2i(b);
    for (int i = 0; i < 4; i++) begin
      s = s + sm2i(bt[i]);
      if (s > 32767) begin
        s = 32767;
        o = 1'b1;
      end else if (s < -32767) begin
        s = -32767;
        o = 1'b1;
      end
    end
    d = i2sm(s);
  endfunction

  function automatic beats_t mk(input logic [15:0] b0, input logic [15:0] b1,
                                input logic [15:0] b2, input logic [15:0] b3);
    beats_t r;
    r[0] = b0;
    r[1] = b1;
    r[2] = b2;
    r[3] = b3;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic do_run(input logic [15:0] b, input beats_t bt,
                        input int gap, input int stall, input bit poke,
                        input logic [15:0] ed, input logic eo,
                        input string tag);
    @(negedge clk);
    bias      = b;
    start     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    start = poke;
    check({tag, " accum_entry"}, {30'd0, busy, in_ready}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(negedge clk);
      end
      if (i == 3) check({tag, " early_valid"}, 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_data  = bt[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    check({tag, " latency"}, 32'(out_valid), 32'd1);
    check({tag, " data"}, 32'(out_data), 32'(ed));
    check({tag, " ovf"}, 32'(out_ovf), 32'(eo));
    check({tag, " add_b_idle"}, 32'(add_b), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, " stall"}, {15'd0, out_valid, out_data},
            {15'd0, 1'b1, ed});
      check({tag, " stall_ovf"}, 32'(out_ovf), 32'(eo));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post_hs"}, {30'd0, busy, out_valid}, 32'd0);
    start = 1'b0;
  endtask

  vec_t        tbl[7];
  beats_t      rb;
  logic [15:0] ed;
  logic        eo;
  beats_t      rbeats[3];
  logic [15:0] rbias[3];
  logic [15:0] red[3];
  logic        reo[3];

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    tbl[0] = '{16'h0000, mk(16'h0003, 16'h0005, 16'h8002, 16'h0001),
               16'h0007, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{16'h7000, mk(16'h7000, 16'h8001, 16'h0000, 16'h0000),
               16'h7FFE, 1'b1, 0, 1, 1'b0};
    tbl[2] = '{16'h0005, mk(16'h8005, 16'h0000, 16'h0000, 16'h0000),
               16'h0000, 1'b0, 0, 0, 1'b0};
    tbl[3] = '{16'h0000, mk(16'h0003, 16'h0005, 16'h8002, 16'h0001),
               16'h0007, 1'b0, 2, 5, 1'b1};
    tbl[4] = '{16'hF000, mk(16'hF000, 16'h0001, 16'h0000, 16'h0000),
               16'hFFFE, 1'b1, 1, 2, 1'b0};
    tbl[5] = '{16'h0001, mk(16'h8002, 16'h0001, 16'h0003, 16'h8000),
               16'h0003, 1'b0, 0, 0, 1'b1};
    tbl[6] = '{16'h8000, mk(16'h0000, 16'h8000, 16'h0000, 16'h0000),
               16'h0000, 1'b0, 0, 0, 1'b0};

    repeat (2) @(negedge clk);
    check("reset outs", {27'd0, in_ready, out_valid, out_ovf, busy, 1'b0},
          32'd0);
    check("reset data", {add_a, out_data}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_run(tbl[i].bias, tbl[i].beats, tbl[i].gap, tbl[i].stall,
             tbl[i].poke, tbl[i].exp_data, tbl[i].exp_ovf,
             $sformatf("vec%0d", i));

    // Abort after two accepted beats.
    @(negedge clk);
    bias  = 16'h0123;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0100;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort ctl", {28'd0, in_ready, out_valid, out_ovf, busy}, 32'd0);
    check("abort data", {out_data, add_a}, 32'd0);
    check("abort add_b", 32'(add_b), 32'd0);
    repeat (3) @(negedge clk);
    check("abort quiet", {30'd0, out_valid, busy}, 32'd0);
    do_run(16'h8004, mk(16'h0001, 16'h0001, 16'h0001, 16'h0001),
           0, 0, 1'b0, 16'h0000, 1'b0, "post_abort");

    // Randomized runs against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] rbi;
      rbi = 16'($urandom);
      for (int k = 0; k < 4; k++)
        rb[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) |
                (16'($urandom_range(0, 1)) << 15) : 16'($urandom);
      ref_run(rbi, rb, ed, eo);
      do_run(rbi, rb, $urandom_range(0, 2), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), ed, eo, $sformatf("rnd%0d", n));
    end

    // start and out_ready tied high: back-to-back runs.
    for (int r = 0; r < 3; r++) begin
      rbias[r] = 16'($urandom_range(0, 16'h3FFF)) |
                 (16'($urandom_range(0, 1)) << 15);
      for (int k = 0; k < 4; k++)
        rbeats[r][k] = 16'($urandom);
      ref_run(rbias[r], rbeats[r], red[r], reo[r]);
    end
    begin
      int r;
      int k;
      int last;
      r    = 0;
      k    = 0;
      last = -1;
      @(negedge clk);
      bias      = rbias[0];
      start     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 60 && r < 3; cyc++) begin
        @(negedge clk);
        if (out_valid) begin
          check($sformatf("tied%0d data", r), 32'(out_data), 32'(red[r]));
          check($sformatf("tied%0d ovf", r), 32'(out_ovf), 32'(reo[r]));
          if (r > 0)
            check($sformatf("tied%0d turnaround", r), 32'(cyc - last), 32'd6);
          last = cyc;
          r++;
          k = 0;
          if (r < 3) bias = rbias[r];
        end else if (in_ready && k < 4) begin
          in_data = rbeats[r][k];
          k++;
        end
      end
      check("tied runs_done", 32'(r), 32'd3);
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      check("tied idle", {30'd0, busy, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
